// File: rtl/reduce_combine.sv
// Receive side of the in-network reduction path: folds contributions per (contextId, tag)
// into a small table and emits one combined flit once every expected contribution has arrived.
module reduce_combine #(
  parameter int         FlitWidth     = 73,
  parameter int         ChildrenWidth = 3,
  parameter int         TableSize     = 4,
  parameter logic [2:0] rank_x        = 3'b0,
  parameter logic [2:0] rank_y        = 3'b0,
  parameter logic [2:0] rank_z        = 3'b0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [FlitWidth+ChildrenWidth-1:0] packetIn,
  output logic                               in_ready,
  output logic [FlitWidth-1:0]               packetOut,
  input  logic                               out_ready
);

  localparam int IdxW = (TableSize > 1) ? $clog2(TableSize) : 1;

  typedef struct packed {
    logic                     busy;
    logic                     done;
    logic [ChildrenWidth-1:0] remaining;
    logic [7:0]               ctx;
    logic [7:0]               tag;
    logic [3:0]               op;
    logic [1:0]               alg;
    logic [8:0]               dst;
    logic [31:0]              acc;
  } entry_t;

  entry_t                 table_q [TableSize];
  entry_t                 table_d [TableSize];
  logic [FlitWidth-1:0]   packet_out_q;
  logic [FlitWidth-1:0]   packet_out_d;

  logic                     in_valid;
  logic [ChildrenWidth-1:0] in_children;
  logic [8:0]               in_dst;
  logic [7:0]               in_ctx;
  logic [7:0]               in_tag;
  logic [1:0]               in_alg;
  logic [3:0]               in_op;
  logic [31:0]              in_payload;
  logic                     unused_src;

  assign in_children = packetIn[FlitWidth +: ChildrenWidth];
  assign in_valid    = packetIn[72];
  assign in_dst      = packetIn[71:63];
  assign in_ctx      = packetIn[53:46];
  assign in_tag      = packetIn[45:38];
  assign in_alg      = packetIn[37:36];
  assign in_op       = packetIn[35:32];
  assign in_payload  = packetIn[31:0];
  assign unused_src  = ^packetIn[62:54];

  function automatic logic [31:0] combine(input logic [3:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      4'd1:    return ($signed(a) > $signed(b)) ? a : b;
      4'd2:    return ($signed(a) < $signed(b)) ? a : b;
      4'd3:    return a & b;
      4'd4:    return a | b;
      4'd5:    return a ^ b;
      default: return a + b;
    endcase
  endfunction

  logic [TableSize-1:0] match_vec;
  logic [TableSize-1:0] free_vec;
  logic [TableSize-1:0] done_vec;
  logic [IdxW-1:0]      match_idx;
  logic [IdxW-1:0]      free_idx;
  logic [IdxW-1:0]      done_idx;
  logic                 match_any;
  logic                 free_any;
  logic                 done_any;
  logic                 accept;
  logic                 out_free;
  logic                 drain;

  // Scanning from the top down leaves the lowest-index hit in each index.
  always_comb begin
    match_vec = '0;
    free_vec  = '0;
    done_vec  = '0;
    match_idx = '0;
    free_idx  = '0;
    done_idx  = '0;
    for (int i = TableSize - 1; i >= 0; i--) begin
      match_vec[i] = table_q[i].busy && !table_q[i].done &&
                     (table_q[i].ctx == in_ctx) && (table_q[i].tag == in_tag);
      free_vec[i]  = !table_q[i].busy;
      done_vec[i]  = table_q[i].busy && table_q[i].done;
      if (match_vec[i]) match_idx = IdxW'(i);
      if (free_vec[i])  free_idx  = IdxW'(i);
      if (done_vec[i])  done_idx  = IdxW'(i);
    end
  end

  assign match_any = |match_vec;
  assign free_any  = |free_vec;
  assign done_any  = |done_vec;
  assign in_ready  = !rst && (match_any || free_any);
  assign accept    = in_valid && in_ready;
  assign out_free  = !packet_out_q[72] || out_ready;
  assign drain     = out_free && done_any;

  always_comb begin
    table_d      = table_q;
    packet_out_d = packet_out_q;

    if (drain) begin
      table_d[done_idx].busy = 1'b0;
      table_d[done_idx].done = 1'b0;
      packet_out_d = {1'b1, table_q[done_idx].dst, rank_z, rank_y, rank_x,
                      table_q[done_idx].ctx, table_q[done_idx].tag,
                      table_q[done_idx].alg, table_q[done_idx].op,
                      table_q[done_idx].acc};
    end else if (out_ready) begin
      packet_out_d = '0;
    end

    // A matched entry is never done, and a free entry is never the one draining.
    if (accept) begin
      if (match_any) begin
        table_d[match_idx].acc       = combine(table_q[match_idx].op,
                                               table_q[match_idx].acc, in_payload);
        table_d[match_idx].remaining = table_q[match_idx].remaining - 1'b1;
        table_d[match_idx].done      = (table_q[match_idx].remaining == ChildrenWidth'(1));
      end else begin
        table_d[free_idx].busy      = 1'b1;
        table_d[free_idx].done      = (in_children == '0);
        table_d[free_idx].remaining = in_children;
        table_d[free_idx].ctx       = in_ctx;
        table_d[free_idx].tag       = in_tag;
        table_d[free_idx].op        = in_op;
        table_d[free_idx].alg       = in_alg;
        table_d[free_idx].dst       = in_dst;
        table_d[free_idx].acc       = in_payload;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TableSize; i++) begin
        table_q[i] <= '0;
      end
      packet_out_q <= '0;
    end else begin
      for (int i = 0; i < TableSize; i++) begin
        table_q[i] <= table_d[i];
      end
      packet_out_q <= packet_out_d;
    end
  end

  assign packetOut = packet_out_q;

endmodule
